// File: rtl/fb_pixel_writer.sv
// Frame buffer write controller: RGB565 stream -> raster RAM writes with ping-pong bank swap.
// Latency: 1 cycle from rgb_en to wr_en/wr_addr/wr_data, all outputs registered.
// Backpressure: none; pixels arriving while a full frame awaits swap_ack are dropped and flag ovf.
// Optional: define FB_PIXEL_WRITER_HMIRROR_EN for horizontally mirrored column addressing.
module fb_pixel_writer #(
  parameter int H_PIX  = 64,
  parameter int V_PIX  = 64,
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sof,
  input  logic              rgb_en,
  input  logic [15:0]       rgb_data,
  input  logic              swap_ack,
  input  logic              ovf_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              swap_req,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              frame_err,
  output logic              ovf
);

  localparam int CW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int RW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam int OW = ADDR_W - 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_PIX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_PIX - 1);
  localparam bit POW2 = ((1 << CW) == H_PIX);

  typedef enum logic {WRITE, WAIT_SWAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col, eff_col, col_term;
  logic [RW-1:0]   row, eff_row;
  logic            wr_bank;
  logic            restart, do_write, col_wrap, frame_end, drop, err;
  logic [OW-1:0]   offset;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= WRITE;
    else          state <= state_nxt;
  end

  // Next state and per-cycle control; sof zeroes the effective position before the pixel uses it
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    do_write  = 1'b0;
    drop      = 1'b0;
    err       = 1'b0;
    col_wrap  = 1'b0;
    frame_end = 1'b0;
    eff_col   = col;
    eff_row   = row;
    case (state)
      WRITE: begin
        if (sof) begin
          restart = 1'b1;
          err     = (col != '0) || (row != '0);
          eff_col = '0;
          eff_row = '0;
        end
        if (rgb_en) begin
          do_write  = 1'b1;
          col_wrap  = (eff_col == COL_LAST);
          frame_end = col_wrap && (eff_row == ROW_LAST);
          if (frame_end) state_nxt = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        drop = rgb_en;
        if (swap_ack) state_nxt = WRITE;
      end
      default: state_nxt = WRITE;
    endcase
  end

`ifdef FB_PIXEL_WRITER_HMIRROR_EN
  assign col_term = COL_LAST - eff_col;
`else
  assign col_term = eff_col;
`endif

  generate
    if (POW2) begin : g_shift
      // Power-of-two line length: the row simply sits above the column bits
      assign offset = OW'({eff_row, col_term});
    end else begin : g_base
      logic [OW-1:0] line_base, eff_base;
      assign eff_base = restart ? '0 : line_base;
      assign offset   = eff_base + OW'(col_term);
      // Running start-of-line address, avoids a row*H_PIX multiplier
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                line_base <= '0;
        else if (do_write && col_wrap) line_base <= frame_end ? '0 : eff_base + OW'(H_PIX);
        else if (restart)            line_base <= '0;
      end
    end
  endgenerate

  // Raster column/row counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (do_write) begin
      if (col_wrap) begin
        col <= '0;
        row <= frame_end ? '0 : eff_row + 1'b1;
      end else begin
        col <= eff_col + 1'b1;
        row <= eff_row;
      end
    end else if (restart) begin
      col <= '0;
      row <= '0;
    end
  end

  // Registered RAM write port, status pulses, bank ownership and sticky overflow
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      rd_bank    <= 1'b1;
      wr_bank    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      wr_en      <= do_write;
      frame_done <= frame_end;
      frame_err  <= err;
      if (do_write) begin
        wr_addr <= {wr_bank, offset};
        wr_data <= rgb_data;
      end
      if (state == WAIT_SWAP && swap_ack) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign swap_req = (state == WAIT_SWAP);

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer (H_PIX=4, V_PIX=2): directed plan plus randomized traffic vs a frame-position model.
module tb_fb_pixel_writer;
  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 13;
  localparam int BANK_OFS = 1 << (AW - 1);

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic sof = 1'b0, rgb_en = 1'b0, swap_ack = 1'b0, ovf_clr = 1'b0;
  logic [15:0] rgb_data = '0;
  logic wr_en, swap_req, rd_bank, frame_done, frame_err, ovf;
  logic [AW-1:0] wr_addr;
  logic [15:0] wr_data;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  fb_pixel_writer #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .sof(sof), .rgb_en(rgb_en), .rgb_data(rgb_data),
    .swap_ack(swap_ack), .ovf_clr(ovf_clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .rd_bank(rd_bank), .frame_done(frame_done),
    .frame_err(frame_err), .ovf(ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position as a plain pixel index
  int   m_pos;
  bit   m_bank, m_wait;
  logic e_wr_en, e_swap_req, e_rd_bank, e_fd, e_fe, e_ovf;
  int   e_wr_addr, e_wr_data;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pos = 0; m_bank = 0; m_wait = 0;
      e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0; e_swap_req = 0;
      e_rd_bank = 1; e_fd = 0; e_fe = 0; e_ovf = 0;
    end else begin
      int  pos, c;
      bit  set_ovf;
      e_wr_en = 0; e_fd = 0; e_fe = 0; set_ovf = 0;
      if (!m_wait) begin
        pos = m_pos;
        if (sof) begin
          if (pos != 0) e_fe = 1;
          pos = 0;
        end
        if (rgb_en) begin
`ifdef FB_PIXEL_WRITER_HMIRROR_EN
          c = H - 1 - (pos % H);
`else
          c = pos % H;
`endif
          e_wr_addr = (m_bank ? BANK_OFS : 0) + (pos / H) * H + c;
          e_wr_data = int'(rgb_data);
          e_wr_en = 1;
          pos++;
          if (pos == H * V) begin
            pos = 0; m_wait = 1; e_fd = 1;
          end
        end
        m_pos = pos;
      end else begin
        if (rgb_en) set_ovf = 1;
        if (swap_ack) begin
          e_rd_bank = m_bank; m_bank = !m_bank; m_wait = 0;
        end
      end
      if (set_ovf) e_ovf = 1;
      else if (ovf_clr) e_ovf = 0;
      e_swap_req = m_wait;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (cmp_on) begin
      chk("wr_en", 32'(wr_en), 32'(e_wr_en));
      chk("wr_addr", 32'(wr_addr), e_wr_addr);
      chk("wr_data", 32'(wr_data), e_wr_data);
      chk("swap_req", 32'(swap_req), 32'(e_swap_req));
      chk("rd_bank", 32'(rd_bank), 32'(e_rd_bank));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("frame_err", 32'(frame_err), 32'(e_fe));
      chk("ovf", 32'(ovf), 32'(e_ovf));
    end
  end

  task automatic drive(input logic s, input logic e, input logic [15:0] d,
                       input logic a, input logic c);
    sof = s; rgb_en = e; rgb_data = d; swap_ack = a; ovf_clr = c;
    @(posedge clock);
    #1;
  endtask

`ifdef FB_PIXEL_WRITER_HMIRROR_EN
  localparam int A0 = 3, A1 = 2, A2 = 1, A7 = 4;
`else
  localparam int A0 = 0, A1 = 1, A2 = 2, A7 = 7;
`endif

  initial begin
    #1 reset_n = 1'b0;
    #1 cmp_on = 1'b1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_bank", 32'(rd_bank), 1);
    chk("rst_swap_req", 32'(swap_req), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Full frame 0x0001..0x0008
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 16'(i), 0, 0);
      if (i == 1) chk("first_addr", 32'(wr_addr), A0);
    end
    chk("last_addr", 32'(wr_addr), A7);
    chk("last_data", 32'(wr_data), 32'h8);
    chk("last_fd", 32'(frame_done), 1);
    chk("last_swap_req", 32'(swap_req), 1);
    chk("last_rd_bank", 32'(rd_bank), 1);

    // Pixels while waiting, then swap
    for (int i = 0; i < 3; i++) drive(0, 1, 16'h00EE, 0, 0);
    chk("drop_wr_en", 32'(wr_en), 0);
    chk("drop_ovf", 32'(ovf), 1);
    drive(0, 0, 16'h0, 1, 0);
    chk("swap_rd_bank", 32'(rd_bank), 0);
    chk("swap_req_clr", 32'(swap_req), 0);
    drive(0, 1, 16'h00AA, 0, 0);
    chk("bank1_addr", 32'(wr_addr), BANK_OFS + A0);
    drive(0, 0, 16'h0, 0, 1);
    chk("ovf_clr", 32'(ovf), 0);

    // Partial frame aborted by sof carrying a pixel
    for (int i = 0; i < 3; i++) drive(0, 1, 16'(16'h10 + i), 0, 0);
    drive(1, 1, 16'h0055, 0, 0);
    chk("sof_err", 32'(frame_err), 1);
    chk("sof_addr", 32'(wr_addr), BANK_OFS + A0);
    chk("sof_data", 32'(wr_data), 32'h55);
    drive(0, 1, 16'h0056, 0, 0);
    chk("after_sof_addr", 32'(wr_addr), BANK_OFS + A1);

    // swap_ack during WRITE is ignored
    drive(0, 0, 16'h0, 1, 0);
    drive(0, 1, 16'h0057, 0, 0);
    chk("ack_ign_addr", 32'(wr_addr), BANK_OFS + A2);
    chk("ack_ign_rd_bank", 32'(rd_bank), 0);
    drive(0, 1, 16'h0058, 0, 0);
    drive(0, 1, 16'h0059, 0, 0);

    // Asynchronous reset mid-frame
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_bank", 32'(rd_bank), 1);
    chk("mid_rst_addr", 32'(wr_addr), 0);
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 1, 16'h0077, 0, 0);
    chk("post_rst_addr", 32'(wr_addr), A0);
    chk("post_rst_err", 32'(frame_err), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7), 16'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end
    drive(0, 0, 16'h0, 0, 0);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Write-side controller between the YCbCr-to-RGB converter and the display frame buffer RAM, in the sysclk domain.
- Consumes the RGB565 pixel stream (rgb_en/rgb_data) and generates raster write addresses with column/row counters.
- Manages a two-bank (ping-pong) frame buffer, handing completed banks to the DSI read side through a swap request/acknowledge handshake.

Parameters:
- H_PIX, 64, pixels per line.
- V_PIX, 64, lines per frame.
- ADDR_W, 13, write address width; MSB is the bank bit, so H_PIX*V_PIX must be <= 2^(ADDR_W-1).

Ports:
- clock  in  1  system clock (sysclk).
- reset_n  in  1  asynchronous active-low reset.
- sof  in  1  start-of-frame pulse; restarts raster position.
- rgb_en  in  1  pixel valid strobe.
- rgb_data  in  16  RGB565 pixel.
- swap_ack  in  1  single-cycle pulse from read side: displayed bank released.
- ovf_clr  in  1  clears sticky overflow flag.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address {bank, row*H_PIX+col}.
- wr_data  out  16  RAM write data.
- swap_req  out  1  completed frame waiting for swap.
- rd_bank  out  1  bank the read side must display.
- frame_done  out  1  one-cycle pulse on the last pixel of a frame.
- frame_err  out  1  one-cycle pulse when sof aborts a partial frame.
- ovf  out  1  sticky flag: pixel dropped while waiting for swap.

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, swap_req=0, rd_bank=1, frame_done=0, frame_err=0, ovf=0. Internal state: wr_bank=0, col=0, row=0, state=WRITE.
- States:
  - WRITE: accepting pixels.
  - WAIT_SWAP: full frame held and swap_req=1.
- WRITE, rgb_en=1:
  - Next cycle: wr_en=1, wr_data=rgb_data, wr_addr={wr_bank, row*H_PIX+col}. Latency is exactly 1 cycle, all outputs registered.
  - col increments. At col=H_PIX-1, col wraps to 0 and row increments.
  - At col=H_PIX-1 and row=V_PIX-1: that pixel is written, frame_done pulses with the write, col/row return to 0, state goes to WAIT_SWAP and swap_req=1 on the same cycle as that write.
- WRITE, rgb_en=0: wr_en=0; wr_addr and wr_data hold their last values.
- WAIT_SWAP:
  - rgb_en pixels are dropped (wr_en stays 0) and ovf is set.
  - On swap_ack: next cycle rd_bank takes the old wr_bank, wr_bank toggles, swap_req=0, state goes to WRITE.
  - An rgb_en in the same cycle as swap_ack is dropped and sets ovf.
- swap_ack in WRITE is ignored.
- sof:
  - In WRITE with col or row nonzero: frame_err pulses, col/row reset to 0, bank unchanged.
  - In WRITE with col=row=0: no error.
  - In WAIT_SWAP: ignored.
  - sof with rgb_en in the same cycle (WRITE): sof takes effect first and the pixel is written to address {wr_bank,0}; the counter then advances to col=1.
- ovf: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it next cycle.
- Width rules:
  - Row*H_PIX+col is computed with counters of width clog2(H_PIX) and clog2(V_PIX), then zero-extended to ADDR_W-1.
  - No multiplier when H_PIX is a power of two; a running line-base register (adds H_PIX per line) is used otherwise.
- Reset asserted mid-frame: all state returns to reset values asynchronously; the partial frame is abandoned with no frame_err.

Optional Feature:
- Macro FB_PIXEL_WRITER_HMIRROR_EN.
- Defined: the column term of the address is (H_PIX-1-col), giving horizontally mirrored panel orientation. Counters, handshake and frame_done timing are unchanged.
- Undefined: addresses are plain raster (col term = col).

Test Plan:
- H_PIX=4,V_PIX=2. Reset, then 8 consecutive rgb_en with data 0x0001..0x0008 → wr_addr 0x000..0x007, one cycle after each strobe. frame_done and swap_req rise with the write of 0x0008 at addr 0x007. rd_bank=1.
- Continue from WAIT_SWAP: 3 rgb_en pulses, then swap_ack → no writes, ovf=1, rd_bank=0 one cycle after ack. The next pixel 0x00AA goes to addr 0x1000 (bank 1); ovf_clr → ovf=0.
- 3 pixels, then sof plus rgb_en with 0x0055 in the same cycle → frame_err pulse; 0x0055 written at {bank,0}; the next pixel goes to offset 1.
- swap_ack pulsed in WRITE mid-frame → ignored: wr_bank and rd_bank unchanged, addresses continue sequentially.
- reset_n low for one cycle mid-frame (after 5 pixels) → all outputs return to reset values immediately. The following frame starts at addr 0x000 in bank 0 with no frame_err.
- With FB_PIXEL_WRITER_HMIRROR_EN: 8 pixels → addresses 3,2,1,0,7,6,5,4; frame_done still on the 8th write.
